// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for MEM-stage loads/stores. One access is accepted
//   per Req handshake in IDLE, held for WAIT_CYCLES wait states, then
//   completed with a one-cycle Ack in RESP. Serves a word RAM plus three
//   memory-mapped registers (LED, free-running TIMER, unmapped-access ERRCNT).
//
// Ports
//   Clk    in   1   clock, rising edge
//   Clrn   in   1   asynchronous reset, active-high
//   Req    in   1   access request (sampled in IDLE only)
//   Wmem   in   1   1 = store, 0 = load
//   Addr   in  32   byte address, bits [1:0] ignored
//   Wdata  in  32   store data
//   Rdata  out 32   load data, valid with Ack, held until the next load Ack
//   Ack    out  1   completion pulse (RESP state)
//   Busy   out  1   transaction in flight (state != IDLE)
//   Led    out 16   LED register
//   Timer  out 32   free-running timer
//   Err    out  1   sticky unmapped-access flag
module data_mem_responder #(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        Req,
    input  logic        Wmem,
    input  logic [31:0] Addr,
    input  logic [31:0] Wdata,
    output logic [31:0] Rdata,
    output logic        Ack,
    output logic        Busy,
    output logic [15:0] Led,
    output logic [31:0] Timer,
    output logic        Err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [29:0] LED_WORD    = 30'h3FFF_C000;  // 0xFFFF_0000
    localparam logic [29:0] TIMER_WORD  = 30'h3FFF_C001;  // 0xFFFF_0004
    localparam logic [29:0] ERRCNT_WORD = 30'h3FFF_C002;  // 0xFFFF_0008

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        accept;
    logic        commit;
    logic        load_rdata;

    logic [29:0] addr_q;
    logic        wmem_q;
    logic [31:0] wdata_q;
    logic [7:0]  errcnt;

    logic [29:0] raddr;
    logic        rwmem;
    logic [31:0] rd_next;

    logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

    // Byte-offset bits are don't-care; the name keeps them out of unused-signal reports.
    logic unused_addr_bits;
    assign unused_addr_bits = ^Addr[1:0];

    function automatic logic is_ram(input logic [29:0] w);
        return (w >> DEPTH_LOG2) == 30'd0;
    endfunction

    function automatic logic is_mapped(input logic [29:0] w);
        return is_ram(w) || (w == LED_WORD) || (w == TIMER_WORD) || (w == ERRCNT_WORD);
    endfunction

    assign Busy   = (state != IDLE);
    assign Ack    = (state == RESP);
    assign commit = (state == RESP);

    // Next-state logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (Req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_next = RESP;
                else             cnt_next   = cnt - 4'd1;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Rdata is captured on the edge entering RESP so it is valid alongside Ack.
    // With no wait states that edge is the accept edge, so the live inputs are
    // used instead of the latched copies.
    always_comb begin
        raddr      = (state == IDLE) ? Addr[31:2] : addr_q;
        rwmem      = (state == IDLE) ? Wmem : wmem_q;
        load_rdata = (state_next == RESP) && (state != RESP) && !rwmem;
        rd_next    = 32'hDEAD_BEEF;
        if (is_ram(raddr))              rd_next = mem[raddr[DEPTH_LOG2-1:0]];
        else if (raddr == LED_WORD)     rd_next = {16'h0000, Led};
        // No store can commit on this edge, so Timer during RESP is Timer+1.
        else if (raddr == TIMER_WORD)   rd_next = Timer + 32'd1;
        else if (raddr == ERRCNT_WORD)  rd_next = {24'h00_0000, errcnt};
    end

    always_ff @(posedge Clk or posedge Clrn) begin
        if (Clrn) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wmem_q  <= 1'b0;
            wdata_q <= '0;
            Rdata   <= '0;
            Led     <= '0;
            Timer   <= '0;
            Err     <= 1'b0;
            errcnt  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                addr_q  <= Addr[31:2];
                wmem_q  <= Wmem;
                wdata_q <= Wdata;
            end
            if (load_rdata) Rdata <= rd_next;

            Timer <= Timer + 32'd1;

            if (commit) begin
                if (!is_mapped(addr_q)) begin
                    Err <= 1'b1;
                    if (errcnt != 8'hFF) errcnt <= errcnt + 8'd1;
                end else if (wmem_q) begin
                    if (addr_q == LED_WORD)    Led   <= wdata_q[15:0];
                    if (addr_q == TIMER_WORD)  Timer <= wdata_q;  // write beats increment
                    if (addr_q == ERRCNT_WORD) begin
                        errcnt <= '0;
                        Err    <= 1'b0;
                    end
                end
            end
        end
    end

    // RAM is not reset; reset forces IDLE asynchronously so no store commits.
    always_ff @(posedge Clk) begin
        if (commit && wmem_q && is_ram(addr_q))
            mem[addr_q[DEPTH_LOG2-1:0]] <= wdata_q;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with 2 wait states,
// one with 0 wait states for back-to-back throughput.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        clrn = 1'b1;
    logic        req = 1'b0, req0 = 1'b0;
    logic        wmem = 1'b0;
    logic [31:0] addr = '0, wdata = '0;

    logic [31:0] rdata, rdata0, timer, timer0;
    logic        ack, ack0, busy, busy0, err, err0;
    logic [15:0] led, led0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
        .Clk(clk), .Clrn(clrn), .Req(req), .Wmem(wmem), .Addr(addr), .Wdata(wdata),
        .Rdata(rdata), .Ack(ack), .Busy(busy), .Led(led), .Timer(timer), .Err(err)
    );

    data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
        .Clk(clk), .Clrn(clrn), .Req(req0), .Wmem(wmem), .Addr(addr), .Wdata(wdata),
        .Rdata(rdata0), .Ack(ack0), .Busy(busy0), .Led(led0), .Timer(timer0), .Err(err0)
    );

    // One access on the selected instance; returns at the negedge of the Ack cycle.
    // Inputs are scrambled right after accept to show they are not re-sampled.
    task automatic access(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat, output int busy_n,
                          output logic [31:0] tim);
        @(negedge clk);
        wmem = w; addr = a; wdata = d;
        if (sel) req0 = 1'b1; else req = 1'b1;
        @(negedge clk);
        req = 1'b0; req0 = 1'b0; wmem = ~w; addr = ~a; wdata = ~d;
        lat = 1;
        busy_n = (sel ? busy0 : busy) ? 1 : 0;
        while (!(sel ? ack0 : ack) && lat < 40) begin
            @(negedge clk);
            lat++;
            if (sel ? busy0 : busy) busy_n++;
        end
        rd  = sel ? rdata0 : rdata;
        tim = sel ? timer0 : timer;
        wmem = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (ack !== 1'b0)        begin n_fail++; $display("FAIL reset_ack got %b exp 0", ack); end
        n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (rdata !== 32'h0)     begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        n_cmp++; if (led !== 16'h0)       begin n_fail++; $display("FAIL reset_led got %h exp 0", led); end
        n_cmp++; if (timer !== 32'h0)     begin n_fail++; $display("FAIL reset_timer got %h exp 0", timer); end
        n_cmp++; if (err !== 1'b0)        begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
        n_cmp++; if (busy0 !== 1'b0)      begin n_fail++; $display("FAIL reset_busy0 got %b exp 0", busy0); end
        clrn = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_cmp++; if (timer !== 32'(i)) begin n_fail++; $display("FAIL timer_count got %h exp %h", timer, 32'(i)); end
        end
    endtask

    task automatic test_ram();
        logic [31:0] rd, tim;
        int lat, bn;
        access(0, 1'b1, 32'h0000_0010, 32'h1234_5678, rd, lat, bn, tim);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL st_latency got %0d exp 3", lat); end
        n_cmp++; if (bn !== 3)  begin n_fail++; $display("FAIL st_busy got %0d exp 3", bn); end
        access(0, 1'b0, 32'h0000_0013, 32'h0, rd, lat, bn, tim);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL ld_latency got %0d exp 3", lat); end
        n_cmp++; if (bn !== 3)  begin n_fail++; $display("FAIL ld_busy got %0d exp 3", bn); end
        n_cmp++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL ld_data got %h exp 12345678", rd); end
        @(negedge clk);
        n_cmp++; if (ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL post_ack got ack=%b busy=%b exp 0 0", ack, busy); end
        n_cmp++; if (rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rdata_hold got %h exp 12345678", rdata); end
        // RAM boundary words
        access(0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, rd, lat, bn, tim);
        access(0, 1'b1, 32'h0000_03FC, 32'hCAFE_0001, rd, lat, bn, tim);
        access(0, 1'b0, 32'h0000_03FC, 32'h0, rd, lat, bn, tim);
        n_cmp++; if (rd !== 32'hCAFE_0001) begin n_fail++; $display("FAIL ram_top got %h exp cafe0001", rd); end
        access(0, 1'b0, 32'h0000_0000, 32'h0, rd, lat, bn, tim);
        n_cmp++; if (rd !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL ram_bottom got %h exp 0badf00d", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, tim;
        int lat, bn;
        int k;
        logic [31:0] vals [4];
        vals[0] = 32'hA000_0000; vals[1] = 32'hA111_1111; vals[2] = 32'hA222_2222; vals[3] = 32'hA333_3333;
        for (int i = 0; i < 4; i++) access(1, 1'b1, 32'(i * 4), vals[i], rd, lat, bn, tim);
        @(negedge clk);
        wmem = 1'b0; addr = 32'h0; req0 = 1'b1;
        k = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n_cmp++; if (ack0 !== ((c % 2) == 1)) begin n_fail++; $display("FAIL b2b_ack_c%0d got %b exp %b", c, ack0, (c % 2) == 1); end
            if (ack0 === 1'b1 && k < 4) begin
                n_cmp++; if (rdata0 !== vals[k]) begin n_fail++; $display("FAIL b2b_data%0d got %h exp %h", k, rdata0, vals[k]); end
                k++;
                addr = 32'(k * 4);
                if (k == 4) req0 = 1'b0;
            end
        end
        req0 = 1'b0;
    endtask

    task automatic test_mmio();
        logic [31:0] rd, tim;
        int lat, bn;
        access(0, 1'b1, 32'hFFFF_0000, 32'h0000_ABCD, rd, lat, bn, tim);
        @(negedge clk);
        n_cmp++; if (led !== 16'hABCD) begin n_fail++; $display("FAIL led got %h exp abcd", led); end
        access(0, 1'b0, 32'hFFFF_0000, 32'h0, rd, lat, bn, tim);
        n_cmp++; if (rd !== 32'h0000_ABCD) begin n_fail++; $display("FAIL led_read got %h exp 0000abcd", rd); end
        access(0, 1'b1, 32'hFFFF_0004, 32'hFFFF_FFFE, rd, lat, bn, tim);
        @(negedge clk);
        n_cmp++; if (timer !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL timer_load got %h exp fffffffe", timer); end
        @(negedge clk);
        n_cmp++; if (timer !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL timer_inc got %h exp ffffffff", timer); end
        @(negedge clk);
        n_cmp++; if (timer !== 32'h0) begin n_fail++; $display("FAIL timer_wrap got %h exp 0", timer); end
        access(0, 1'b0, 32'hFFFF_0004, 32'h0, rd, lat, bn, tim);
        n_cmp++; if (rd !== tim)   begin n_fail++; $display("FAIL timer_read got %h exp %h", rd, tim); end
        n_cmp++; if (rd !== 32'd4) begin n_fail++; $display("FAIL timer_read_abs got %h exp 4", rd); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd, tim;
        int lat, bn;
        access(0, 1'b0, 32'h0000_0400, 32'h0, rd, lat, bn, tim);
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL unmapped_rd got %h exp deadbeef", rd); end
        @(negedge clk);
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b exp 1", err); end
        access(0, 1'b0, 32'hFFFF_0008, 32'h0, rd, lat, bn, tim);
        n_cmp++; if (rd !== 32'd1) begin n_fail++; $display("FAIL errcnt_1 got %h exp 1", rd); end
        // An unmapped store must not alias onto RAM word 0
        access(0, 1'b1, 32'h0000_0400, 32'h1111_1111, rd, lat, bn, tim);
        access(0, 1'b0, 32'h0000_0000, 32'h0, rd, lat, bn, tim);
        n_cmp++; if (rd !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL no_alias got %h exp 0badf00d", rd); end
        for (int i = 0; i < 300; i++)
            access(0, 1'(i % 2), (i % 3 == 0) ? 32'hFFFF_000C : 32'h0000_0400 + 32'(i * 4), 32'(i), rd, lat, bn, tim);
        access(0, 1'b0, 32'hFFFF_0008, 32'h0, rd, lat, bn, tim);
        n_cmp++; if (rd !== 32'd255) begin n_fail++; $display("FAIL errcnt_sat got %h exp ff", rd); end
        n_cmp++; if (err !== 1'b1)   begin n_fail++; $display("FAIL err_sticky got %b exp 1", err); end
        access(0, 1'b1, 32'hFFFF_0008, 32'h5A5A_5A5A, rd, lat, bn, tim);
        @(negedge clk);
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", err); end
        access(0, 1'b0, 32'hFFFF_0008, 32'h0, rd, lat, bn, tim);
        n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL errcnt_clear got %h exp 0", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, tim;
        int lat, bn;
        int acks;
        access(0, 1'b1, 32'h0000_0020, 32'h0000_55AA, rd, lat, bn, tim);
        @(negedge clk);
        wmem = 1'b1; addr = 32'h0000_0020; wdata = 32'hFFFF_FFFF; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b exp 1", busy); end
        clrn = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy got %b exp 0", busy); end
        acks = 0;
        repeat (3) begin @(negedge clk); if (ack !== 1'b0) acks++; end
        clrn = 1'b0;
        wmem = 1'b0;
        repeat (4) begin @(negedge clk); if (ack !== 1'b0) acks++; end
        n_cmp++; if (acks !== 0)    begin n_fail++; $display("FAIL rst_no_ack got %0d exp 0", acks); end
        n_cmp++; if (led !== 16'h0) begin n_fail++; $display("FAIL rst_led got %h exp 0", led); end
        access(0, 1'b0, 32'h0000_0020, 32'h0, rd, lat, bn, tim);
        n_cmp++; if (rd !== 32'h0000_55AA) begin n_fail++; $display("FAIL rst_no_commit got %h exp 000055aa", rd); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_back_to_back();
        test_mmio();
        test_unmapped();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
